axis_pi_v1_0: RTL and testbench

AXIS_PI_V1_0 -- requirements
Module: axis_pi_v1_0

---
 rtl/axis_pi_v1_0_pkg.sv | 26 ++
 rtl/axis_pi_sat.sv | 17 +
 rtl/axis_pi_v1_0.sv | 136 +++++++++++++
 tb/tb_axis_pi_v1_0.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pi_v1_0_pkg.sv
// Shared defaults and the signed clamp helper for the AXI-Stream PI controller.
// The clamp works on 64-bit signed values so callers of any width can share it.
package axis_pi_v1_0_pkg;

    localparam int DEF_INOUT_WIDTH            = 16;
    localparam int DEF_INOUT_DECIMAL_WIDTH    = 14;
    localparam int DEF_GAIN_WIDTH             = 16;
    localparam int DEF_GAIN_DECIMAL_WIDTH     = 14;
    localparam int DEF_INTERNAL_WIDTH         = 16;
    localparam int DEF_INTERNAL_DECIMAL_WIDTH = 14;

    function automatic logic signed [63:0] satClamp(
        input logic signed [63:0] value,
        input logic signed [63:0] lo,
        input logic signed [63:0] hi
    );
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/axis_pi_sat.sv
// Limit comparison and clamp of a signed value into [min_i, max_i].
// The caller recovers the saturation side by comparing the result with the input.
module axis_pi_sat
    import axis_pi_v1_0_pkg::*;
#(
    parameter int VALUE_WIDTH = DEF_INTERNAL_WIDTH,
    parameter int LIMIT_WIDTH = DEF_INOUT_WIDTH
) (
    input  logic signed [VALUE_WIDTH-1:0] value_i,
    input  logic signed [LIMIT_WIDTH-1:0] max_i,
    input  logic signed [LIMIT_WIDTH-1:0] min_i,
    output logic signed [LIMIT_WIDTH-1:0] clamped_o
);

    assign clamped_o = LIMIT_WIDTH'(satClamp(64'(value_i), 64'(min_i), 64'(max_i)));

endmodule

// File: rtl/axis_pi_v1_0.sv
// PI controller on AXI-Stream samples: one step per accepted input sample,
// full-precision integrator with conditional anti-windup, registered clamped output.
module axis_pi_v1_0
    import axis_pi_v1_0_pkg::*;
#(
    parameter int inout_width            = DEF_INOUT_WIDTH,
    parameter int inout_decimal_width    = DEF_INOUT_DECIMAL_WIDTH,
    parameter int gain_width             = DEF_GAIN_WIDTH,
    parameter int gain_decimal_width     = DEF_GAIN_DECIMAL_WIDTH,
    parameter int internal_width         = DEF_INTERNAL_WIDTH,
    parameter int internal_decimal_width = DEF_INTERNAL_DECIMAL_WIDTH
) (
    input  logic                          aclk,
    input  logic                          resetn,
    input  logic signed [gain_width-1:0]  kp,
    input  logic signed [gain_width-1:0]  ki,
    input  logic signed [inout_width-1:0] output_max,
    input  logic signed [inout_width-1:0] output_min,
    input  logic signed [inout_width-1:0] s_axis_input_tdata,
    input  logic                          s_axis_input_tvalid,
    input  logic                          s_axis_input_tlast,
    output logic                          s_axis_input_tready,
    input  logic signed [inout_width-1:0] s_axis_reference_tdata,
    input  logic                          s_axis_reference_tvalid,
    input  logic                          s_axis_reference_tlast,
    output logic                          s_axis_reference_tready,
    output logic signed [inout_width-1:0] m_axis_output_tdata,
    output logic                          m_axis_output_tvalid,
    output logic                          m_axis_output_tlast,
    input  logic                          m_axis_output_tready
);

    localparam int ERR_W  = inout_width + 1;
    localparam int PROD_W = ERR_W + gain_width;
    localparam int ACC_W  = inout_width + gain_width + 8;
    localparam int SUM_W  = ACC_W + 1;
    localparam logic signed [63:0] INT_MAX = (64'sd1 <<< (internal_width - 1)) - 64'sd1;
    localparam logic signed [63:0] INT_MIN = -(64'sd1 <<< (internal_width - 1));

    if (internal_width < inout_width || internal_decimal_width != inout_decimal_width) begin : g_formatCheck
        $error("axis_pi_v1_0: internal format must cover the inout format");
    end

    logic signed [ERR_W-1:0]          err;
    logic signed [PROD_W-1:0]         prop;
    logic signed [PROD_W-1:0]         inc;
    logic signed [ACC_W-1:0]          acc_q;
    logic signed [ACC_W-1:0]          acc_d;
    logic signed [SUM_W-1:0]          sum;
    logic signed [SUM_W-1:0]          sumShifted;
    logic signed [internal_width-1:0] u_q;
    logic signed [internal_width-1:0] u_d;
    logic signed [inout_width-1:0]    uPrevClamped;
    logic signed [inout_width-1:0]    outData_d;
    logic signed [inout_width-1:0]    outData_q;
    logic                             outValid_q;
    logic                             outLast_q;
    logic                             atMax;
    logic                             atMin;
    logic                             beyondLimit;
    logic                             integrate;
    logic                             unused_inputs;

    assign unused_inputs = ^{m_axis_output_tready, s_axis_reference_tvalid, s_axis_reference_tlast};

    assign err  = ERR_W'(s_axis_reference_tdata) - ERR_W'(s_axis_input_tdata);
    assign prop = PROD_W'(err) * PROD_W'(kp);
    assign inc  = PROD_W'(err) * PROD_W'(ki);

    // Anti-windup looks at where the previous unsaturated sum sat against today's limits.
    axis_pi_sat #(
        .VALUE_WIDTH(internal_width),
        .LIMIT_WIDTH(inout_width)
    ) u_satPrev (
        .value_i  (u_q),
        .max_i    (output_max),
        .min_i    (output_min),
        .clamped_o(uPrevClamped)
    );

    assign atMax       = (uPrevClamped == output_max);
    assign atMin       = (uPrevClamped == output_min);
    assign beyondLimit = (internal_width'(uPrevClamped) != u_q);

    always_comb begin
        integrate = 1'b0;
        if (!atMax && !atMin) begin
            integrate = 1'b1;
        end else if (beyondLimit && atMax) begin
            integrate = inc[PROD_W-1];
        end else if (beyondLimit && atMin) begin
            integrate = !inc[PROD_W-1] && (inc != '0);
        end
    end

    assign acc_d      = integrate ? (acc_q + ACC_W'(inc)) : acc_q;
    assign sum        = SUM_W'(prop) + SUM_W'(acc_d);
    assign sumShifted = sum >>> gain_decimal_width;
    // Pinning to the internal range keeps the ordering against the limits intact.
    assign u_d        = internal_width'(satClamp(64'(sumShifted), INT_MIN, INT_MAX));

    axis_pi_sat #(
        .VALUE_WIDTH(internal_width),
        .LIMIT_WIDTH(inout_width)
    ) u_satOut (
        .value_i  (u_d),
        .max_i    (output_max),
        .min_i    (output_min),
        .clamped_o(outData_d)
    );

    always_ff @(posedge aclk or posedge resetn) begin
        if (resetn) begin
            acc_q      <= '0;
            u_q        <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
        end else begin
            outValid_q <= s_axis_input_tvalid;
            if (s_axis_input_tvalid) begin
                acc_q     <= acc_d;
                u_q       <= u_d;
                outData_q <= outData_d;
                outLast_q <= s_axis_input_tlast;
            end
        end
    end

    assign s_axis_input_tready     = !resetn;
    assign s_axis_reference_tready = !resetn;
    assign m_axis_output_tdata     = outData_q;
    assign m_axis_output_tvalid    = outValid_q;
    assign m_axis_output_tlast     = outLast_q;

endmodule

// File: tb/tb_axis_pi_v1_0.sv
// Self-checking bench for axis_pi_v1_0: directed PI scenarios plus randomized
// samples, all compared against a value-level real-arithmetic controller model.
module tb_axis_pi_v1_0;

    logic               aclk = 1'b0;
    logic               resetn;
    logic signed [15:0] kp;
    logic signed [15:0] ki;
    logic signed [15:0] outMax;
    logic signed [15:0] outMin;
    logic signed [15:0] inData;
    logic               inValid;
    logic               inLast;
    logic               inReady;
    logic signed [15:0] refData;
    logic               refValid;
    logic               refLast;
    logic               refReady;
    logic signed [15:0] outData;
    logic               outValid;
    logic               outLast;
    logic               outReady;

    int checks = 0;
    int errors = 0;

    real    modelAcc;
    longint modelU;
    longint modelOut;
    logic   modelValid;
    logic   modelLast;

    always #5 aclk = ~aclk;

    axis_pi_v1_0 dut (
        .aclk                   (aclk),
        .resetn                 (resetn),
        .kp                     (kp),
        .ki                     (ki),
        .output_max             (outMax),
        .output_min             (outMin),
        .s_axis_input_tdata     (inData),
        .s_axis_input_tvalid    (inValid),
        .s_axis_input_tlast     (inLast),
        .s_axis_input_tready    (inReady),
        .s_axis_reference_tdata (refData),
        .s_axis_reference_tvalid(refValid),
        .s_axis_reference_tlast (refLast),
        .s_axis_reference_tready(refReady),
        .m_axis_output_tdata    (outData),
        .m_axis_output_tvalid   (outValid),
        .m_axis_output_tlast    (outLast),
        .m_axis_output_tready   (outReady)
    );

    // Single comparison point: counts every check and reports any out-of-tolerance value.
    task automatic checkOutput(input string tag, input longint observed, input longint expected, input longint tol);
        longint diff;
        diff = observed - expected;
        checks++;
        if (diff > tol || diff < -tol) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", tag, observed, expected, tol);
        end
    endtask

    function automatic longint clampL(input longint v, input longint lo, input longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic modelReset();
        modelAcc   = 0.0;
        modelU     = 0;
        modelOut   = 0;
        modelValid = 1'b0;
        modelLast  = 1'b0;
    endtask

    // One controller step in real-valued output units using the quantised gains.
    task automatic modelStep(input longint refV, input longint inV, input logic last);
        longint e;
        real    incR;
        real    uR;
        bit     allow;
        longint lo;
        longint hi;
        lo    = longint'(outMin);
        hi    = longint'(outMax);
        e     = refV - inV;
        incR  = real'(e) * real'(longint'(ki)) / 16384.0;
        allow = (modelU > lo && modelU < hi) || (modelU > hi && incR < 0.0) || (modelU < lo && incR > 0.0);
        if (allow) modelAcc = modelAcc + incR;
        uR         = real'(e) * real'(longint'(kp)) / 16384.0 + modelAcc;
        modelU     = longint'($floor(uR));
        modelOut   = clampL(modelU, lo, hi);
        modelValid = 1'b1;
        modelLast  = last;
    endtask

    task automatic applyStimulus(input longint refV, input longint inV, input logic valid, input logic last,
                                 input bit check, input string tag);
        @(negedge aclk);
        refData  = 16'(refV);
        inData   = 16'(inV);
        inValid  = valid;
        inLast   = last;
        refValid = valid;
        refLast  = last;
        @(posedge aclk);
        if (valid) modelStep(refV, inV, last);
        else       modelValid = 1'b0;
        #1;
        if (check) begin
            checkOutput({tag, " data"}, longint'(outData), modelOut, 10);
            checkOutput({tag, " valid"}, longint'(outValid), longint'(modelValid), 0);
            checkOutput({tag, " last"}, longint'(outLast), longint'(modelLast), 0);
        end
    endtask

    task automatic doReset();
        @(negedge aclk);
        resetn  = 1'b1;
        inValid = 1'b0;
        modelReset();
        @(negedge aclk);
        resetn = 1'b0;
    endtask

    initial begin
        resetn   = 1'b1;
        kp       = '0;
        ki       = '0;
        outMax   = 16'sd32767;
        outMin   = -16'sd32768;
        inData   = '0;
        refData  = '0;
        inValid  = 1'b0;
        inLast   = 1'b0;
        refValid = 1'b0;
        refLast  = 1'b0;
        outReady = 1'b1;
        modelReset();

        #12;
        checkOutput("reset data", longint'(outData), 0, 0);
        checkOutput("reset valid", longint'(outValid), 0, 0);
        checkOutput("reset last", longint'(outLast), 0, 0);
        checkOutput("reset in_ready", longint'(inReady), 0, 0);
        checkOutput("reset ref_ready", longint'(refReady), 0, 0);
        @(negedge aclk);
        resetn = 1'b0;
        #1;
        checkOutput("in_ready", longint'(inReady), 1, 0);
        checkOutput("ref_ready", longint'(refReady), 1, 0);

        // Proportional only: -1638 * 0.01 floors to -17, valid for a single cycle.
        kp = 16'sd164;
        ki = 16'sd0;
        applyStimulus(0, 1638, 1'b1, 1'b1, 1'b1, "p_only");
        checkOutput("p_only value", longint'(outData), -17, 0);
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b1, "p_idle");
        checkOutput("p_idle hold", longint'(outData), -17, 0);

        doReset();
        kp = 16'sd0;
        ki = 16'sd16;
        for (int n = 0; n < 551; n++) applyStimulus(0, 2457, 1'b1, 1'b0, 1'b1, "i_only");
        checkOutput("i_only final", longint'(outData), -1322, 10);

        doReset();
        kp     = 16'sd13107;
        ki     = 16'sd164;
        outMax = 16'sd31129;
        outMin = -16'sd31129;
        for (int n = 0; n < 300; n++) applyStimulus(16384, 0, 1'b1, 1'b0, 1'b1, "sat_hi");
        checkOutput("sat_hi final", longint'(outData), 31129, 0);
        for (int n = 0; n < 300; n++) applyStimulus(-16384, 0, 1'b1, 1'b0, 1'b1, "sat_lo");
        checkOutput("sat_lo final", longint'(outData), -31129, 0);

        // Asynchronous reset in the middle of a clock period while saturated.
        for (int n = 0; n < 150; n++) applyStimulus(16384, 0, 1'b1, 1'b1, 1'b1, "pre_rst");
        @(negedge aclk);
        #2;
        resetn = 1'b1;
        #1;
        checkOutput("async_rst data", longint'(outData), 0, 0);
        checkOutput("async_rst valid", longint'(outValid), 0, 0);
        checkOutput("async_rst last", longint'(outLast), 0, 0);
        checkOutput("async_rst in_ready", longint'(inReady), 0, 0);
        checkOutput("async_rst ref_ready", longint'(refReady), 0, 0);
        inValid = 1'b0;
        ki      = 16'sd0;
        modelReset();
        @(negedge aclk);
        resetn = 1'b0;
        applyStimulus(16384, 0, 1'b1, 1'b0, 1'b1, "post_rst");
        checkOutput("post_rst p_term", longint'(outData), 13107, 0);

        doReset();
        kp     = 16'sd13107;
        ki     = 16'sd164;
        outMax = 16'sd32767;
        outMin = -16'sd32768;
        for (int n = 0; n < 1000; n++) applyStimulus(-16384, modelOut, 1'b1, 1'b0, 1'b1, "loop_neg");
        for (int n = 0; n < 1000; n++) applyStimulus(18022, modelOut, 1'b1, 1'b0, 1'b1, "loop_pos");

        doReset();
        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 0) begin
                kp     = 16'(int'($urandom_range(0, 32768)) - 16384);
                ki     = 16'(int'($urandom_range(0, 1024)) - 512);
                outMax = 16'(int'($urandom_range(100, 32767)));
                outMin = 16'(-int'($urandom_range(100, 32768)));
            end
            applyStimulus(longint'(int'($urandom_range(0, 65535)) - 32768),
                          longint'(int'($urandom_range(0, 65535)) - 32768),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0), 1'b1, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
